// File: rtl/axis_pkg.sv
// -----------------------------------------------------------------------------
// axis_pkg
// Shared definitions for the AXI-stream frame-length limiter.
//   state_t          : limiter FSM states (IDLE / XFER / DROP)
//   axis_*_bit/width : sideband packing of one beat as {tlast, tuser, tdata},
//                      the same word layout the upstream async FIFO stores.
// -----------------------------------------------------------------------------
package axis_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    function automatic int axis_word_width(input int data_width);
        return data_width + 2;
    endfunction

    function automatic int axis_user_bit(input int data_width);
        return data_width;
    endfunction

    function automatic int axis_last_bit(input int data_width);
        return data_width + 1;
    endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// -----------------------------------------------------------------------------
// axis_skid_reg
// Registered 2-entry skid stage: a main (output) register plus a temp register
// that catches the one beat accepted in the cycle the output stalls. Both the
// output and the upstream ready are registered; 1 beat/cycle sustained.
// Ports:
//   clk, async_rst          : clock, asynchronous active-high reset
//   s_data_i/s_valid_i      : upstream beat
//   s_ready_o               : registered ready (= temp register empty)
//   m_data_o/m_valid_o      : downstream beat
//   m_ready_i               : downstream ready
// -----------------------------------------------------------------------------
module axis_skid_reg #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             async_rst,
    input  logic [WIDTH-1:0] s_data_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i
);

    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [WIDTH-1:0] tmp_data_q,  tmp_data_d;
    logic             main_valid_q, main_valid_d;
    logic             tmp_valid_q,  tmp_valid_d;
    logic             ready_q,      ready_d;
    logic             in_xfer;

    assign in_xfer = s_valid_i && ready_q;

    // NOTE: every _d gets its hold value first, so no path through this block
    // can leave a signal unassigned and infer a latch.
    always_comb begin
        main_data_d  = main_data_q;
        main_valid_d = main_valid_q;
        tmp_data_d   = tmp_data_q;
        tmp_valid_d  = tmp_valid_q;

        if (m_ready_i || !main_valid_q) begin
            // Main register is free this cycle: refill from temp first so
            // beat order is preserved; temp full implies ready_q was low.
            if (tmp_valid_q) begin
                main_data_d  = tmp_data_q;
                main_valid_d = 1'b1;
                tmp_valid_d  = 1'b0;
            end else begin
                main_valid_d = in_xfer;
                if (in_xfer) begin
                    main_data_d = s_data_i;
                end
            end
        end else if (in_xfer) begin
            // Output stalled but ready was already promised: park the beat.
            tmp_data_d  = s_data_i;
            tmp_valid_d = 1'b1;
        end

        ready_d = !tmp_valid_d;
    end

    // NOTE: the data registers are reset too because the output bus must read
    // zero during reset; they are flops, not a memory array.
    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            main_data_q  <= '0;
            main_valid_q <= 1'b0;
            tmp_data_q   <= '0;
            tmp_valid_q  <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            main_data_q  <= main_data_d;
            main_valid_q <= main_valid_d;
            tmp_data_q   <= tmp_data_d;
            tmp_valid_q  <= tmp_valid_d;
            ready_q      <= ready_d;
        end
    end

    assign s_ready_o = ready_q;
    assign m_data_o  = main_data_q;
    assign m_valid_o = main_valid_q;

endmodule

// File: rtl/axis_frame_len_limit.sv
// -----------------------------------------------------------------------------
// axis_frame_len_limit
// AXI-stream stage that caps frame length in beats. A frame longer than the
// limit is cut at the limit beat (forced tlast=1, tuser=1) and the remainder
// of the frame is consumed and discarded. Output goes through axis_skid_reg.
// Ports:
//   clk, async_rst       : clock, asynchronous active-high reset
//   max_len              : beat limit (0 = unlimited), latched at frame start
//   input_axis_*         : upstream AXI-stream (tdata/tvalid/tready/tlast/tuser)
//   output_axis_*        : downstream AXI-stream
//   frame_count          : frames whose tlast beat was accepted downstream
//   trunc_count          : frames truncated
//   busy                 : high while in XFER or DROP
// -----------------------------------------------------------------------------
module axis_frame_len_limit
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  async_rst,
    input  logic [LEN_WIDTH-1:0]  max_len,
    input  logic [DATA_WIDTH-1:0] input_axis_tdata,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    input  logic                  input_axis_tlast,
    input  logic                  input_axis_tuser,
    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    output logic                  output_axis_tlast,
    output logic                  output_axis_tuser,
    output logic [CNT_WIDTH-1:0]  frame_count,
    output logic [CNT_WIDTH-1:0]  trunc_count,
    output logic                  busy
);

    localparam int WORD_W   = axis_word_width(DATA_WIDTH);
    localparam int USER_BIT = axis_user_bit(DATA_WIDTH);
    localparam int LAST_BIT = axis_last_bit(DATA_WIDTH);

    state_t               state_q, state_d;
    logic [LEN_WIDTH-1:0] lim_q, lim_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0] trunc_cnt_q, trunc_cnt_d;

    logic [LEN_WIDTH-1:0] lim_eff, cnt_eff;
    logic                 trunc_hit, beat_last, beat_user;
    logic                 skid_valid, skid_ready, fwd_xfer, out_last_xfer;
    logic [WORD_W-1:0]    skid_in, skid_out;

    // On a frame start the limit and count come from this beat, not from the
    // registers, so the check applies to beat 1 as well (lim=1 cuts at once).
    assign lim_eff   = (state_q == ST_IDLE) ? max_len : lim_q;
    assign cnt_eff   = (state_q == ST_IDLE) ? LEN_WIDTH'(1) : cnt_q + LEN_WIDTH'(1);
    assign trunc_hit = (lim_eff != '0) && (cnt_eff == lim_eff) && !input_axis_tlast;
    assign beat_last = input_axis_tlast | trunc_hit;
    assign beat_user = input_axis_tuser | trunc_hit;

    // In DROP nothing reaches the skid and upstream is drained unconditionally.
    assign skid_valid        = input_axis_tvalid && (state_q != ST_DROP);
    assign fwd_xfer          = skid_valid && skid_ready;
    assign input_axis_tready = (state_q == ST_DROP) || skid_ready;
    assign skid_in           = {beat_last, beat_user, input_axis_tdata};
    assign out_last_xfer     = output_axis_tvalid && output_axis_tready && output_axis_tlast;

    always_comb begin
        state_d     = state_q;
        lim_d       = lim_q;
        cnt_d       = cnt_q;
        frame_cnt_d = frame_cnt_q;
        trunc_cnt_d = trunc_cnt_q;

        case (state_q)
            ST_IDLE, ST_XFER: begin
                if (fwd_xfer) begin
                    lim_d = lim_eff;
                    cnt_d = cnt_eff;
                    if (trunc_hit) begin
                        state_d     = ST_DROP;
                        trunc_cnt_d = trunc_cnt_q + CNT_WIDTH'(1);
                    end else if (input_axis_tlast) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_XFER;
                    end
                end
            end
            ST_DROP: begin
                if (input_axis_tvalid && input_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (out_last_xfer) begin
            frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state_q     <= ST_IDLE;
            lim_q       <= '0;
            cnt_q       <= '0;
            frame_cnt_q <= '0;
            trunc_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            lim_q       <= lim_d;
            cnt_q       <= cnt_d;
            frame_cnt_q <= frame_cnt_d;
            trunc_cnt_q <= trunc_cnt_d;
        end
    end

    axis_skid_reg #(
        .WIDTH (WORD_W)
    ) u_skid (
        .clk       (clk),
        .async_rst (async_rst),
        .s_data_i  (skid_in),
        .s_valid_i (skid_valid),
        .s_ready_o (skid_ready),
        .m_data_o  (skid_out),
        .m_valid_o (output_axis_tvalid),
        .m_ready_i (output_axis_tready)
    );

    assign output_axis_tdata = skid_out[DATA_WIDTH-1:0];
    assign output_axis_tuser = skid_out[USER_BIT];
    assign output_axis_tlast = skid_out[LAST_BIT];
    assign frame_count       = frame_cnt_q;
    assign trunc_count       = trunc_cnt_q;
    assign busy              = (state_q != ST_IDLE);

endmodule

// File: doc/axis_frame_len_limit.md
Name: axis_frame_len_limit

Overview:
- Single-clock AXI-stream stage placed directly downstream of the async FIFO's output port, in the consuming clock domain.
- Enforces a maximum frame length in beats. A frame that exceeds the limit is cut at the limit beat: that beat is forced to tlast=1 and tuser=1 (bad frame), and the rest of the frame is discarded.
- Forwards traffic through a registered skid output at full throughput and keeps frame and truncation counters.

Parameters:
DATA_WIDTH, 8, tdata width
LEN_WIDTH, 16, width of max_len and of the internal beat counter
CNT_WIDTH, 32, width of the statistics counters

Ports:
clk  in  1  clock; all logic on rising edge
async_rst  in  1  asynchronous active-high reset
max_len  in  LEN_WIDTH  beat limit per frame; 0 = no limit; sampled on first beat of each frame
input_axis_tdata  in  DATA_WIDTH  input data
input_axis_tvalid  in  1  input valid
input_axis_tready  out  1  input ready
input_axis_tlast  in  1  input end of frame
input_axis_tuser  in  1  input bad-frame flag
output_axis_tdata  out  DATA_WIDTH  output data
output_axis_tvalid  out  1  output valid
output_axis_tready  in  1  output ready
output_axis_tlast  out  1  output end of frame
output_axis_tuser  out  1  output bad-frame flag
frame_count  out  CNT_WIDTH  frames emitted (tlast beats accepted downstream)
trunc_count  out  CNT_WIDTH  frames truncated
busy  out  1  high while in XFER or DROP

Behaviour:
- Reset: async_rst asynchronously clears all state to the values below; release is synchronous to clk.
  - output_axis_tvalid/tdata/tlast/tuser = 0; input_axis_tready = 0; counters = 0; busy = 0; state = IDLE.
  - input_axis_tready rises on the first clk edge after reset deasserts.
- Handshake: a beat transfers when tvalid && tready on a rising edge. Output tvalid, once high, holds with stable data until output_axis_tready.
- Output path: 2-entry skid (main reg + temp reg). Latency 1 cycle input-to-output; 1 beat/cycle sustained.
  - input_axis_tready is registered: it equals "temp reg empty" for the next cycle.
  - Accepts one beat after output stalls, held in temp.
- States:
  - IDLE: next accepted beat is a frame start. Latch lim = max_len, cnt = 1, then apply the limit check.
  - XFER: each accepted beat increments cnt (LEN_WIDTH, no wrap needed since truncation bounds it).
  - Limit check on every forwarded beat: lim != 0 && cnt == lim && !tlast → forward the beat with tlast=1, tuser=1; trunc_count++; go to DROP.
  - tlast forwarded (natural or forced) → go to IDLE. Otherwise IDLE → XFER.
  - DROP: input_axis_tready forced 1 regardless of the output side; beats are discarded, not forwarded. Accepted beat with tlast → IDLE.
- Boundaries:
  - Beat number lim carrying tlast=1 is a normal frame: not truncated, tuser passes unchanged.
  - Single-beat frame (tlast on first beat) goes IDLE → IDLE.
  - lim=1 with no tlast on the first beat truncates immediately.
  - Incoming tuser=1 passes through unchanged.
  - max_len changes mid-frame are ignored until the next frame start.
- frame_count increments when the output tlast beat is accepted downstream.
- Both counters wrap modulo 2^CNT_WIDTH. If both events occur in one cycle, each counter updates independently.
- Reset mid-frame: the partial frame in flight is lost. The first beat accepted after reset is treated as a frame start, even if it is the tail of an upstream frame.
- Entering DROP while the skid holds data: the held beats still drain normally to the output.

Decomposition:
- Shared package axis_pkg:
  - state localparams ST_IDLE=2'd0, ST_XFER=2'd1, ST_DROP=2'd2
  - AXIS sideband bit positions {tlast, tuser, tdata}, consistent with the FIFO's memory word packing
- One natural sub-module: axis_skid_reg, the registered 2-entry skid output stage with async reset. The FSM, beat counter and statistics stay in the top.

Test Plan:
- max_len=4; frame of 3 beats (0x11,0x22,0x33; tlast on 0x33), output_axis_tready=1 → identical 3 beats out, 1-cycle latency, tuser=0; frame_count=1, trunc_count=0.
- max_len=4; 7-beat frame 0x01..0x07 → output 0x01..0x04, with 0x04 tlast=1 tuser=1. Beats 0x05..0x07 are consumed with tready=1 and not output. trunc_count=1, frame_count=1.
- max_len=4; 4-beat frame with tlast on beat 4 → no truncation, tuser=0; next frame of 2 beats passes intact; frame_count=2.
- max_len=0; 300-beat frame → all 300 beats pass, no truncation. Also: max_len changed to 2 on beat 5 → no effect on this frame.
- Output backpressure: output_axis_tready toggles 1,0,0,1 during continuous input → no beat lost or duplicated; input_axis_tready drops 1 cycle after the stall; full rate resumes.
- async_rst pulsed mid-frame during DROP → all outputs 0 immediately. After release, the next beat starts a new frame; counters read 0 before it.
